// File: rtl/regfile_if.sv
// Decode/writeback side bus of the integer register file.
//   rd_addr1/rd_reg1_flag -> rd_data1 : read port 1 (rs1)
//   rd_addr2/rd_reg2_flag -> rd_data2 : read port 2 (rs2)
//   wb_wr_en/wb_wr_addr/wb_wr_data    : single write port from writeback
//   dbg_addr -> dbg_data              : always-valid debug/trace read port
// master: the requester (decode, writeback, trace); slave: the register file.
interface regfile_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [AW-1:0]   rd_addr1;
  logic            rd_reg1_flag;
  logic [XLEN-1:0] rd_data1;
  logic [AW-1:0]   rd_addr2;
  logic            rd_reg2_flag;
  logic [XLEN-1:0] rd_data2;
  logic            wb_wr_en;
  logic [AW-1:0]   wb_wr_addr;
  logic [XLEN-1:0] wb_wr_data;
  logic [AW-1:0]   dbg_addr;
  logic [XLEN-1:0] dbg_data;

  modport master (
    output rd_addr1, rd_reg1_flag, rd_addr2, rd_reg2_flag,
    output wb_wr_en, wb_wr_addr, wb_wr_data, dbg_addr,
    input  rd_data1, rd_data2, dbg_data
  );

  modport slave (
    input  rd_addr1, rd_reg1_flag, rd_addr2, rd_reg2_flag,
    input  wb_wr_en, wb_wr_addr, wb_wr_data, dbg_addr,
    output rd_data1, rd_data2, dbg_data
  );
endinterface

// File: rtl/regfile.sv
// Integer register file x0..x31 with two zero-latency read ports, one
// writeback write port with internal write-through, and a debug read port.
// Ports:
//   clk   : system clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset; clears every register and forces
//           all read data to 0 while low
//   bus   : regfile_if slave modport (read ports 1/2, write port, debug port)
// x0 has no storage; it always reads 0 and writes to it are dropped.
module regfile #(
  parameter int XLEN    = 32,
  parameter int REG_NUM = 32,
  parameter int AW      = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  regfile_if.slave   bus
);

  // Storage starts at x1: x0 is hardwired to zero.
  logic [XLEN-1:0] regs [1:REG_NUM-1];

  logic [XLEN-1:0] stored1;
  logic [XLEN-1:0] stored2;
  logic [XLEN-1:0] stored_dbg;

  // Read resolution for one port, highest priority first: reset, invalid
  // request, x0, same-cycle write (write-through), then the stored value.
  // The stored value is the current array contents, never its next state.
  function automatic logic [XLEN-1:0] resolve(
    input logic            rst_ok,
    input logic            flag,
    input logic [AW-1:0]   addr,
    input logic            wen,
    input logic [AW-1:0]   waddr,
    input logic [XLEN-1:0] wdata,
    input logic [XLEN-1:0] stored
  );
    logic [XLEN-1:0] res;
    if (!rst_ok)
      res = '0;
    else if (!flag)
      res = '0;
    else if (addr == '0)
      res = '0;
    else if (wen && (waddr == addr))
      res = wdata;
    else
      res = stored;
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Any write presented during reset is discarded.
      for (int i = 1; i < REG_NUM; i++)
        regs[i] <= '0;
    end else if (bus.wb_wr_en && (bus.wb_wr_addr != '0)) begin
      regs[bus.wb_wr_addr] <= bus.wb_wr_data;
    end
  end

  // Guard the x0 lookup so the array is never indexed below x1.
  assign stored1    = (bus.rd_addr1 == '0) ? '0 : regs[bus.rd_addr1];
  assign stored2    = (bus.rd_addr2 == '0) ? '0 : regs[bus.rd_addr2];
  assign stored_dbg = (bus.dbg_addr == '0) ? '0 : regs[bus.dbg_addr];

  assign bus.rd_data1 = resolve(rst_n, bus.rd_reg1_flag, bus.rd_addr1,
                                bus.wb_wr_en, bus.wb_wr_addr, bus.wb_wr_data,
                                stored1);
  assign bus.rd_data2 = resolve(rst_n, bus.rd_reg2_flag, bus.rd_addr2,
                                bus.wb_wr_en, bus.wb_wr_addr, bus.wb_wr_data,
                                stored2);
  // The debug port follows the same rules with its valid tied high.
  assign bus.dbg_data = resolve(rst_n, 1'b1, bus.dbg_addr,
                                bus.wb_wr_en, bus.wb_wr_addr, bus.wb_wr_data,
                                stored_dbg);

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios followed by random
// traffic, compared against an array model of the architectural registers.
module tb_regfile;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [XLEN-1:0] model [32];

  always #5 clk = ~clk;

  regfile_if #(.XLEN(XLEN), .AW(AW)) bus ();

  regfile #(.XLEN(XLEN), .REG_NUM(32), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Architectural read value for the currently driven inputs.
  function automatic logic [XLEN-1:0] exp_read(input logic f, input logic [AW-1:0] a);
    if (!rst_n || !f || a == '0) return '0;
    if (bus.wb_wr_en && bus.wb_wr_addr == a) return bus.wb_wr_data;
    return model[a];
  endfunction

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_in(input logic r,
                        input logic [AW-1:0] a1, input logic f1,
                        input logic [AW-1:0] a2, input logic f2,
                        input logic we, input logic [AW-1:0] wa,
                        input logic [XLEN-1:0] wd, input logic [AW-1:0] da);
    rst_n            = r;
    bus.rd_addr1     = a1;
    bus.rd_reg1_flag = f1;
    bus.rd_addr2     = a2;
    bus.rd_reg2_flag = f2;
    bus.wb_wr_en     = we;
    bus.wb_wr_addr   = wa;
    bus.wb_wr_data   = wd;
    bus.dbg_addr     = da;
  endtask

  task automatic set_rand(input logic r);
    set_in(r, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           32'($urandom), 5'($urandom_range(0, 31)));
  endtask

  // Inputs settle at the falling edge; compare 1 time unit later.
  task automatic check_ports(input string tag);
    #1;
    chk({tag, "_p1"},  bus.rd_data1, exp_read(bus.rd_reg1_flag, bus.rd_addr1));
    chk({tag, "_p2"},  bus.rd_data2, exp_read(bus.rd_reg2_flag, bus.rd_addr2));
    chk({tag, "_dbg"}, bus.dbg_data, exp_read(1'b1, bus.dbg_addr));
  endtask

  // Clock edge: the model commits the write rules, then back to the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else if (bus.wb_wr_en && bus.wb_wr_addr != '0) begin
      model[bus.wb_wr_addr] = bus.wb_wr_data;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;
    set_in(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);

    // Power-up reset with random traffic: all outputs read 0.
    for (int i = 0; i < 2; i++) begin
      set_rand(1'b0);
      check_ports("por");
      chk("por_zero1", bus.rd_data1, 32'h0);
      tick();
    end

    // Random writes, then reset for two cycles.
    for (int i = 0; i < 40; i++) begin
      set_rand(1'b1);
      check_ports("prefill");
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      set_in(1'b0, 5'(i + 3), 1'b1, 5'(i + 4), 1'b1, 1'b1, 5'(i + 3), 32'hCAFE_F00D, 5'(i + 3));
      check_ports("rst_hold");
      chk("rst_hold_d1", bus.rd_data1, 32'h0);
      chk("rst_hold_d2", bus.rd_data2, 32'h0);
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      set_in(1'b1, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 5'(i));
      #1 chk("rst_dbg_zero", bus.dbg_data, 32'h0);
      @(negedge clk);
    end

    // Basic write then read, valid and invalid.
    set_in(1'b1, '0, 1'b0, '0, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, '0);
    check_ports("basic_wr");
    tick();
    set_in(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, '0, '0, 5'd5);
    #1 chk("basic_rd1", bus.rd_data1, 32'hDEAD_BEEF);
    chk("basic_rd2_noflag", bus.rd_data2, 32'h0);
    chk("basic_dbg", bus.dbg_data, 32'hDEAD_BEEF);
    @(negedge clk);
    set_in(1'b1, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, '0, '0, 5'd5);
    #1 chk("basic_flag0", bus.rd_data1, 32'h0);
    @(negedge clk);

    // Write to x0 while reading x0.
    set_in(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 32'h1234_5678, 5'd0);
    #1 chk("x0_same_p1", bus.rd_data1, 32'h0);
    chk("x0_same_p2", bus.rd_data2, 32'h0);
    chk("x0_same_dbg", bus.dbg_data, 32'h0);
    tick();
    set_in(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, '0, '0, 5'd0);
    #1 chk("x0_next_p1", bus.rd_data1, 32'h0);
    chk("x0_next_dbg", bus.dbg_data, 32'h0);
    @(negedge clk);

    // Write-through on both ports at once.
    set_in(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 5'd7, 32'hA5A5_0001, 5'd7);
    #1 chk("wt_p1", bus.rd_data1, 32'hA5A5_0001);
    chk("wt_p2", bus.rd_data2, 32'hA5A5_0001);
    chk("wt_dbg", bus.dbg_data, 32'hA5A5_0001);
    tick();

    // Reset discards a concurrent write.
    set_in(1'b1, '0, 1'b0, '0, 1'b0, 1'b1, 5'd9, 32'h0000_1111, '0);
    tick();
    set_in(1'b0, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1, 5'd9, 32'hFFFF_FFFF, 5'd9);
    #1 chk("rstmid_p1", bus.rd_data1, 32'h0);
    tick();
    set_in(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, '0, '0, 5'd9);
    #1 chk("rstmid_x9_p1", bus.rd_data1, 32'h0);
    chk("rstmid_x9_p2", bus.rd_data2, 32'h0);
    chk("rstmid_x9_dbg", bus.dbg_data, 32'h0);
    @(negedge clk);

    // Sweep: x[i] = i * 0x01010101 read back through every port.
    for (int i = 1; i < 32; i++) begin
      set_in(1'b1, '0, 1'b0, '0, 1'b0, 1'b1, 5'(i), 32'(i) * 32'h0101_0101, '0);
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      logic [XLEN-1:0] e1, e2;
      e1 = 32'(i) * 32'h0101_0101;
      e2 = 32'(31 - i) * 32'h0101_0101;
      set_in(1'b1, 5'(i), 1'b1, 5'(31 - i), 1'b1, 1'b0, '0, '0, 5'(i));
      #1 chk("sweep_p1", bus.rd_data1, e1);
      chk("sweep_p2", bus.rd_data2, e2);
      chk("sweep_dbg", bus.dbg_data, e1);
      @(negedge clk);
    end

    // Random traffic with occasional reset.
    for (int i = 0; i < 300; i++) begin
      set_rand(($urandom_range(0, 29) != 0));
      if ($urandom_range(0, 3) == 0) begin
        bus.rd_addr2 = bus.rd_addr1;
        bus.wb_wr_addr = bus.rd_addr1;
      end
      check_ports("rand");
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
